// File: rtl/bomberman_nios2_qsys_0_cpu_div_cell.sv
// Multi-cycle radix-2 restoring divider with a fixed 33-cycle latency.
// It handles signed and unsigned operands and stalls on the M_en pipeline
// enable. Results sit in registers until the next completion overwrites them.
module bomberman_nios2_qsys_0_cpu_div_cell (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] E_src1,
    input  logic [31:0] E_src2,
    input  logic        div_signed,
    input  logic        div_start,
    input  logic        M_en,
    output logic [31:0] M_div_quot,
    output logic [31:0] M_div_rem,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;     // remaining dividend bits; quotient bits shift in at the bottom
    logic [DW-1:0] rem_q, rem_d;     // partial remainder
    logic [DW-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          dz_q, dz_d;       // divisor was zero
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] remo_q, remo_d;
    logic          busy_q, busy_d;

    logic [DW:0]   pr;
    logic [DW:0]   diff;
    logic          qbit;
    logic [DW-1:0] rem_step;
    logic [DW-1:0] dvd_step;
    logic [DW-1:0] fin_quot;
    logic [DW-1:0] fin_rem;
    logic [DW-1:0] mag_a;
    logic [DW-1:0] mag_b;

    // One restoring step, plus sign fix-up of the would-be final result
    always_comb begin
        pr       = {rem_q, dvd_q[DW-1]};
        diff     = pr - {1'b0, dvs_q};
        qbit     = ~diff[DW];
        rem_step = qbit ? diff[DW-1:0] : pr[DW-1:0];
        dvd_step = {dvd_q[DW-2:0], qbit};
        if (dz_q) begin
            fin_quot = {DW{1'b1}};
        end else if (qneg_q) begin
            fin_quot = DW'(0) - dvd_step;
        end else begin
            fin_quot = dvd_step;
        end
        fin_rem  = (rneg_q && (rem_step != DW'(0))) ? (DW'(0) - rem_step) : rem_step;
        mag_a    = (div_signed && E_src1[DW-1]) ? (DW'(0) - E_src1) : E_src1;
        mag_b    = (div_signed && E_src2[DW-1]) ? (DW'(0) - E_src2) : E_src2;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (div_start && M_en) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    dvd_d   = mag_a;
                    rem_d   = '0;
                    dvs_d   = mag_b;
                    qneg_d  = div_signed && (E_src1[DW-1] ^ E_src2[DW-1]);
                    rneg_d  = div_signed && E_src1[DW-1];
                    dz_d    = (E_src2 == DW'(0));
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (M_en) begin
                    dvd_d = dvd_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q + 1'b1;
                    // Last step lands the signed result so it is visible throughout FINISH
                    if (cnt_q == CW'(DW - 1)) begin
                        state_d = ST_FINISH;
                        busy_d  = 1'b0;
                        quot_d  = fin_quot;
                        remo_d  = fin_rem;
                    end
                end
            end
            ST_FINISH: begin
                if (M_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
        end
    end

    assign M_div_quot = quot_q;
    assign M_div_rem  = remo_q;
    assign busy       = busy_q;
    // Pulse only while FINISH is actually consumed; a stalled FINISH defers it
    assign done       = (state_q == ST_FINISH) && M_en;

endmodule

// File: doc/bomberman_nios2_qsys_0_cpu_div_cell.md
BOMBERMAN_NIOS2_QSYS_0_CPU_DIV_CELL -- requirements
Module: bomberman_nios2_qsys_0_cpu_div_cell

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 E_src1  input  32  dividend; sampled only on an accepted start.
REQ-005 E_src2  input  32  divisor; sampled only on an accepted start.
REQ-006 div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on an accepted start.
REQ-007 div_start  input  1  request a new division; accepted only when busy=0.
REQ-008 M_en  input  1  pipeline enable; when 0, all iteration state and outputs SHALL hold.
REQ-009 M_div_quot  output  32  quotient; registered.
REQ-010 M_div_rem  output  32  remainder; registered.
REQ-011 busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-012 done  output  1  single-cycle pulse marking that M_div_quot and M_div_rem are valid.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
- IDLE -> RUN on div_start=1 with M_en=1.
- RUN -> FINISH after 32 enabled iterations.
- FINISH -> IDLE after one enabled cycle.
REQ-014 Start acceptance SHALL be div_start=1 and M_en=1 and state IDLE; div_start in RUN or FINISH SHALL be ignored.
REQ-015 On acceptance the block SHALL latch operand magnitudes.
- Magnitudes are absolute values when div_signed=1, raw values otherwise.
- The block SHALL also latch the quotient-negate flag (sign1 XOR sign2) and the remainder-negate flag (sign1).
REQ-016 RUN SHALL perform one radix-2 restoring step per enabled cycle.
- Step: 33-bit partial remainder = (rem<<1)|next dividend bit; subtract the divisor if the result is non-negative; shift the quotient bit in.
REQ-017 Latency SHALL be fixed: with acceptance at edge N and M_en continuously 1, done SHALL be high in cycle N+33 and busy high in cycles N+1..N+32.
REQ-018 Each M_en=0 cycle during RUN or FINISH SHALL extend the latency by exactly one cycle.
REQ-019 In FINISH the block SHALL write the final result to M_div_quot and M_div_rem.
- Quotient is negated if the quotient-negate flag is set.
- Remainder is negated if the remainder-negate flag is set and the remainder is non-zero.
REQ-020 Divisor zero SHALL NOT shorten latency.
- Result SHALL be M_div_quot=0xFFFFFFFF and M_div_rem=original E_src1, regardless of div_signed.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield M_div_quot=0x80000000 and M_div_rem=0 with no trap.
REQ-022 M_div_quot and M_div_rem SHALL hold their last values until the next FINISH; they SHALL NOT change during RUN.
REQ-023 done SHALL be high only in FINISH with M_en=1, and never for two consecutive cycles.
REQ-024 A new start SHALL be acceptable in the cycle immediately after done (back-to-back operation).

Reset
REQ-025 On reset_n=0, asynchronously:
- state SHALL be IDLE;
- busy=0 and done=0;
- M_div_quot=0 and M_div_rem=0;
- all iteration registers SHALL be 0.
REQ-026 A reset asserted mid-RUN SHALL abandon the operation with no done pulse.
- After release, the block SHALL accept a new start on the first enabled cycle.

Verification
REQ-027 Unsigned 100/7, start at cycle 0 -> done at cycle 33, quot=14, rem=2; busy high cycles 1..32.
REQ-028 Signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
REQ-029 Divide by zero: E_src1=0x00001234, E_src2=0 (both div_signed values) -> quot=0xFFFFFFFF, rem=0x00001234, done at cycle 33.
REQ-030 Signed 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-031 Stall and ignored start, unsigned 1000/10:
- M_en=0 for 5 cycles during RUN -> done at cycle 38, quot=100, rem=0.
- div_start pulsed at cycle 10 with other operands -> ignored, result unaffected.
REQ-032 reset_n=0 at cycle 15 of a run -> busy=0, done never pulses, outputs 0; a new start after release completes normally in 33 cycles.
